fifo_rd_ctrl: RTL
=================

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 Parameter DW, default 8: data width of FIFO read data and output data.
REQ-002 Parameter CW, default 16: width of the pop counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 fifo_empty  input  1  FIFO empty flag, sampled same cycle as fifo_rd_en.
REQ-006 fifo_rd_en  output  1  FIFO pop request, one word per asserted cycle.
REQ-007 fifo_rd_data  input  DW  FIFO read data, valid exactly one cycle after fifo_rd_en.
REQ-008 m_valid  output  1  downstream data valid.
REQ-009 m_ready  input  1  downstream ready; transfer when m_valid && m_ready.
REQ-010 m_data  output  DW  downstream data, oldest buffered word.
REQ-011 flush  input  1  discard buffered and in-flight data, suppress pops while high.
REQ-012 state  output  2  FSM state: IDLE=00, RUN=01, STALL=10, FLUSH=11.
REQ-013 pop_count  output  CW  number of fifo_rd_en cycles since reset, modulo 2^CW.

Function
REQ-014 The block SHALL keep a 2-entry in-order output buffer (occ = 0..2) and a 1-bit in-flight flag (pend), with invariant occ + pend <= 2.
REQ-015 fifo_rd_en SHALL be high iff !fifo_empty && !flush && state != FLUSH && (occ + pend - pop) < 2, where pop = m_valid && m_ready in the same cycle.
REQ-016 fifo_rd_en SHALL never be asserted while fifo_empty is high, so the FIFO never sees a read-on-empty request.
REQ-017 pend SHALL be set on the cycle after fifo_rd_en and cleared on the following cycle, when fifo_rd_data is written into the buffer tail.
REQ-018 m_valid SHALL equal (occ != 0); m_data SHALL be the head entry, held stable while m_valid && !m_ready.
REQ-019 On a simultaneous pop and data arrival, the head SHALL be removed and the arriving word appended in the same cycle, occ unchanged.
REQ-020 Sustained throughput SHALL be one word per cycle when the FIFO is non-empty and m_ready is held high; latency from first fifo_rd_en to m_valid SHALL be 2 cycles.
REQ-021 Transitions: IDLE->RUN on fifo_rd_en; RUN->STALL when occ==2 && !m_ready; STALL->RUN on pop; RUN->IDLE when occ==0 && pend==0 && no fifo_rd_en.
REQ-022 Any state SHALL go to FLUSH when flush is high; on entry, occ SHALL clear to 0 and m_valid SHALL drop the next cycle.
REQ-023 In FLUSH, data arriving for a pending read SHALL be discarded; FLUSH->IDLE when flush is low and pend==0.
REQ-024 pop_count SHALL increment by 1 on every cycle with fifo_rd_en high and wrap from 2^CW-1 to 0.
REQ-025 fifo_empty rising while a read is pending SHALL not cancel that read; the returned word SHALL still be buffered.

Reset
REQ-026 While rst_n is low: fifo_rd_en=0, m_valid=0, m_data=0, occ=0, pend=0, state=IDLE, pop_count=0, asynchronously.
REQ-027 Reset asserted mid-transfer SHALL drop all buffered and in-flight data; the first fifo_rd_en after release SHALL occur no earlier than the first rising edge with rst_n high.

Verification
REQ-028 FIFO holds 0x11,0x22,0x33, m_ready=1 -> fifo_rd_en high 3 consecutive cycles, m_data 0x11,0x22,0x33 on consecutive cycles starting 2 cycles after first pop, pop_count=3.
REQ-029 4 words available, m_ready=0 -> exactly 2 pops, occ=2, state=STALL, m_data=first word held stable; raising m_ready drains in order with no loss or duplicate.
REQ-030 fifo_empty=1 throughout with m_ready toggling -> fifo_rd_en never asserted, m_valid=0, state=IDLE.
REQ-031 flush pulsed 1 cycle while occ=1 and pend=1 -> m_valid=0 next cycle, in-flight word never appears on m_data, state FLUSH then IDLE, next pop resumes with fresh data.
REQ-032 CW=4, 17 words streamed -> pop_count reads 1 after the 17th pop (wrap at 16).
REQ-033 rst_n pulled low with occ=2 -> m_valid and fifo_rd_en drop immediately without a clock edge, all outputs at reset values.

Source files
------------

// File: rtl/fifo_rd_ctrl_if.sv
// fifo_rd_ctrl_if -- FIFO-side and downstream-side signals of the read controller.
//
//   fifo_empty   : FIFO empty flag (FIFO -> controller)
//   fifo_rd_en   : pop request, one word per asserted cycle (controller -> FIFO)
//   fifo_rd_data : read data, valid exactly one cycle after fifo_rd_en (FIFO -> controller)
//   m_valid      : downstream data valid (controller -> sink)
//   m_ready      : downstream ready (sink -> controller)
//   m_data       : downstream data, oldest buffered word (controller -> sink)
//
// Handshake: a downstream transfer happens on every rising edge where
// m_valid && m_ready; m_data is held stable while m_valid && !m_ready.
//
// Modports: master = the read controller, slave = FIFO + downstream sink.
interface fifo_rd_ctrl_if #(
  parameter int DW = 8
);
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;

  modport master (
    input  fifo_empty, fifo_rd_data, m_ready,
    output fifo_rd_en, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_rd_data, m_ready,
    input  fifo_rd_en, m_valid, m_data
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl -- pops a synchronous-read FIFO (one-cycle read latency) and
// presents the words on a valid/ready stream through a 2-entry output buffer,
// sustaining one word per cycle.
//
// Ports:
//   clk       : clock, all state updates on rising edge
//   rst_n     : asynchronous active-low reset
//   flush     : discard buffered and in-flight data, suppress pops while high
//   bus       : fifo_rd_ctrl_if.master (FIFO read side + downstream stream)
//   state     : FSM state, IDLE=00 RUN=01 STALL=10 FLUSH=11
//   pop_count : number of fifo_rd_en cycles since reset, wraps at 2^CW
module fifo_rd_ctrl #(
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  fifo_rd_ctrl_if.master bus,
  output logic [1:0]     state,
  output logic [CW-1:0]  pop_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    STALL = 2'b10,
    FLUSH = 2'b11
  } state_t;

  state_t        st;
  logic [1:0]    occ;        // buffered words, 0..2
  logic          pend;       // a read was issued last cycle; its data is on fifo_rd_data now
  logic [DW-1:0] buf0;       // head
  logic [DW-1:0] buf1;       // tail when occ == 2

  logic          pop;
  logic          rd_en;
  logic          discard;
  logic [1:0]    occ_nxt;
  logic [DW-1:0] buf0_nxt;
  logic [DW-1:0] buf1_nxt;

  assign pop = bus.m_valid && bus.m_ready;

  // Pop only if the word will have a slot: occ + pend - pop < 2, rewritten
  // as occ + pend < 2 + pop to stay unsigned. Gated by rst_n so the request
  // drops asynchronously with reset.
  assign rd_en = rst_n && !bus.fifo_empty && !flush && (st != FLUSH) &&
                 (({1'b0, occ} + {2'b00, pend}) < (3'd2 + {2'b00, pop}));

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = (occ != 2'd0);
  assign bus.m_data     = buf0;
  assign state          = st;

  // Returning data is dropped both on the cycle flush is raised and while in FLUSH.
  assign discard = flush || (st == FLUSH);

  // Buffer update: remove the head first, then append the arriving word at
  // the resulting tail, so a simultaneous pop + arrival leaves occ unchanged.
  always_comb begin
    occ_nxt  = occ;
    buf0_nxt = buf0;
    buf1_nxt = buf1;
    if (pop) begin
      occ_nxt  = occ - 2'd1;
      buf0_nxt = buf1;
    end
    if (pend && !discard) begin
      if (occ_nxt == 2'd0) buf0_nxt = bus.fifo_rd_data;
      else                 buf1_nxt = bus.fifo_rd_data;
      occ_nxt = occ_nxt + 2'd1;
    end
    if (flush) occ_nxt = 2'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ  <= 2'd0;
      pend <= 1'b0;
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      occ  <= occ_nxt;
      pend <= rd_en;
      buf0 <= buf0_nxt;
      buf1 <= buf1_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_count <= '0;
    end else if (rd_en) begin
      pop_count <= pop_count + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
    end else if (flush) begin
      st <= FLUSH;
    end else begin
      case (st)
        IDLE:    if (rd_en) st <= RUN;
        RUN: begin
          if (occ == 2'd2 && !bus.m_ready)               st <= STALL;
          else if (occ == 2'd0 && !pend && !rd_en)       st <= IDLE;
        end
        STALL:   if (pop) st <= RUN;
        FLUSH:   if (!pend) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

endmodule
